// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the serial instruction-memory loader.
// Imported by imem_loader and ldr_word_packer.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StCount = 3'd1,
    StData  = 3'd2,
    StCheck = 3'd3,
    StDone  = 3'd4,
    StErr   = 3'd5
  } ldr_state_e;

  localparam logic [7:0] LdrMagic = 8'hA5;
  localparam logic [1:0] LaneLast = 2'd3;

  // A COUNT byte of zero stands for a full memory image of 2^addr_w words.
  function automatic int unsigned frame_words(input logic [7:0] count,
                                              input int unsigned addr_w);
    return (count == 8'd0) ? (32'd1 << addr_w) : 32'(count);
  endfunction

endpackage

// File: rtl/ldr_word_packer.sv
// Assembles little-endian 32-bit words from a byte stream, one byte per push.
// The completed word is presented combinationally with the push of its last byte.
module ldr_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_done
);

  logic [31:0] shift_q, shift_d;
  logic [1:0]  lane_q, lane_d;

  // Bytes enter at the top and move down, so the first byte ends up in [7:0].
  assign word      = {data, shift_q[31:8]};
  assign word_done = push & (lane_q == LaneLast);

  always_comb begin
    shift_d = shift_q;
    lane_d  = lane_q;
    if (clear) begin
      shift_d = '0;
      lane_d  = '0;
    end else if (push) begin
      shift_d = word;
      lane_d  = lane_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      lane_q  <= '0;
    end else begin
      shift_q <= shift_d;
      lane_q  <= lane_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Serial program loader: parses MAGIC/COUNT/data/CHK frames, writes words into the
// instruction memory and holds the core in reset until a verified image is present.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter logic [7:0]  MAGIC  = LdrMagic
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error
);

  // Wide enough for both the raw COUNT byte and a full 2^ADDR_W image.
  localparam int unsigned CntW = (ADDR_W + 1 > 8) ? ADDR_W + 1 : 8;

  ldr_state_e        state_q, state_d;
  logic              xfer, is_magic, pack_clear, pack_push, word_done;
  logic [31:0]       word;
  logic [CntW-1:0]   remain_q, remain_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        chk_q, chk_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              in_ready_q, in_ready_d;
  logic              core_hold_q, core_hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  assign xfer       = in_valid & in_ready_q;
  assign is_magic   = (in_data == MAGIC);
  assign pack_clear = xfer & (state_q == StCount);
  assign pack_push  = xfer & (state_q == StData);

  ldr_word_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (pack_clear),
    .push      (pack_push),
    .data      (in_data),
    .word      (word),
    .word_done (word_done)
  );

  // State register, with the FSM-derived outputs registered alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      core_hold_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      core_hold_q <= core_hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (xfer) begin
      unique case (state_q)
        StIdle:  if (is_magic) state_d = StCount;
        StCount: state_d = StData;
        StData:  if (word_done && remain_q == CntW'(1)) state_d = StCheck;
        StCheck: state_d = (in_data == chk_q) ? StDone : StErr;
        StDone:  if (is_magic) state_d = StCount;
        StErr:   if (is_magic) state_d = StCount;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state change.
  always_comb begin
    done_d      = (state_d == StDone);
    error_d     = (state_d == StErr);
    core_hold_d = (state_d != StDone);
  end

  always_comb begin
    remain_d    = remain_q;
    idx_d       = idx_q;
    chk_d       = chk_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (pack_clear) begin
      remain_d = CntW'(frame_words(in_data, ADDR_W));
      idx_d    = '0;
      chk_d    = '0;
    end
    if (pack_push) begin
      chk_d = chk_q ^ in_data;
      if (word_done) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = idx_q;
        mem_wdata_d = word;
        idx_d       = idx_q + ADDR_W'(1);
        remain_d    = remain_q - CntW'(1);
      end
    end
    // Stalling the write cycle keeps the source from racing ahead of the write port.
    in_ready_d = ~mem_we_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      remain_q    <= '0;
      idx_q       <= '0;
      chk_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      remain_q    <= remain_d;
      idx_q       <= idx_d;
      chk_q       <= chk_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign core_hold = core_hold_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: hand-built frames with hand-computed writes,
// checksums, status flags and stall counts.
module tb_imem_loader;

  localparam int unsigned AddrW = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             mem_we;
  logic [AddrW-1:0] mem_addr;
  logic [31:0]      mem_wdata;
  logic             core_hold;
  logic             done;
  logic             error;

  imem_loader #(
    .ADDR_W (AddrW),
    .MAGIC  (8'hA5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_hold (core_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // Write and stall log, sampled on the falling edge.
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  int unsigned stall_cnt = 0;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr_log.push_back(32'(mem_addr));
      wr_data_log.push_back(mem_wdata);
    end
    if (in_valid && !in_ready) stall_cnt++;
  end

  // Inputs change 1 time unit after a rising edge; returns 1 unit after the transfer edge.
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && waited < 16) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!in_ready) check_eq("ready_wait", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  logic [7:0] frame[$];

  task automatic send_frame();
    foreach (frame[i]) send_byte(frame[i]);
    in_valid = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic h);
    check_eq({tag, "_done"}, 32'(done), 32'(d));
    check_eq({tag, "_error"}, 32'(error), 32'(e));
    check_eq({tag, "_hold"}, 32'(core_hold), 32'(h));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, 32'(in_ready), 32'd1);
    check_eq({tag, "_we"}, 32'(mem_we), 32'd0);
    check_eq({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check_eq({tag, "_wdata"}, mem_wdata, 32'd0);
    check_status(tag, 1'b0, 1'b0, 1'b1);
  endtask

  int unsigned wbase;
  int unsigned sbase;
  logic [31:0] exp_word;

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single word, checking write latency and the write-cycle stall directly.
    wbase = wr_addr_log.size();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h13);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    check_eq("f1_we", 32'(mem_we), 32'd1);
    check_eq("f1_ready_low", 32'(in_ready), 32'd0);
    check_eq("f1_addr", 32'(mem_addr), 32'd0);
    check_eq("f1_wdata", mem_wdata, 32'h0000_0013);
    send_byte(8'h13);
    in_valid = 1'b0;
    check_status("f1", 1'b1, 1'b0, 1'b0);
    check_eq("f1_writes", wr_addr_log.size() - wbase, 32'd1);

    // Two words from DONE; checksum 93^00^50^00^13^01^A0^00 = 71.
    wbase = wr_addr_log.size();
    sbase = stall_cnt;
    send_byte(8'hA5);
    check_status("f2_restart", 1'b0, 1'b0, 1'b1);
    frame = '{8'h02, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};
    send_frame();
    check_status("f2", 1'b1, 1'b0, 1'b0);
    check_eq("f2_writes", wr_addr_log.size() - wbase, 32'd2);
    check_eq("f2_addr0", wr_addr_log[wbase], 32'd0);
    check_eq("f2_data0", wr_data_log[wbase], 32'h0050_0093);
    check_eq("f2_addr1", wr_addr_log[wbase+1], 32'd1);
    check_eq("f2_data1", wr_data_log[wbase+1], 32'h00A0_0113);
    check_eq("f2_stalls", stall_cnt - sbase, 32'd2);

    // Bad checksum, then recovery with a good frame.
    wbase = wr_addr_log.size();
    frame = '{8'hA5, 8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'hFF};
    send_frame();
    check_status("f3_bad", 1'b0, 1'b1, 1'b1);
    check_eq("f3_writes", wr_addr_log.size() - wbase, 32'd1);
    send_byte(8'hA5);
    check_status("f3_restart", 1'b0, 1'b0, 1'b1);
    frame = '{8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    send_frame();
    check_status("f3_good", 1'b1, 1'b0, 1'b0);

    // Reset after the second data byte: no write, outputs back at reset values.
    wbase = wr_addr_log.size();
    frame = '{8'hA5, 8'h02, 8'h11, 8'h22};
    send_frame();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_outputs("midrst");
    check_eq("midrst_writes", wr_addr_log.size() - wbase, 32'd0);

    // Leading junk in IDLE is discarded; checksum EF^BE^AD^DE = 22.
    wbase = wr_addr_log.size();
    frame = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    send_frame();
    check_status("junk", 1'b1, 1'b0, 1'b0);
    check_eq("junk_writes", wr_addr_log.size() - wbase, 32'd1);
    check_eq("junk_addr", wr_addr_log[wbase], 32'd0);
    check_eq("junk_data", wr_data_log[wbase], 32'hDEAD_BEEF);

    // COUNT=0: full 64-word image of bytes 0..255, whose XOR is 00.
    wbase = wr_addr_log.size();
    sbase = stall_cnt;
    frame = '{8'hA5, 8'h00};
    for (int k = 0; k < 256; k++) frame.push_back(8'(k));
    frame.push_back(8'h00);
    send_frame();
    check_status("full", 1'b1, 1'b0, 1'b0);
    check_eq("full_writes", wr_addr_log.size() - wbase, 32'd64);
    check_eq("full_stalls", stall_cnt - sbase, 32'd64);
    if (wr_addr_log.size() - wbase == 64) begin
      for (int i = 0; i < 64; i++) begin
        exp_word = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
        check_eq($sformatf("full_addr%0d", i), wr_addr_log[wbase+i], 32'(i));
        check_eq($sformatf("full_data%0d", i), wr_data_log[wbase+i], exp_word);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
